// File: rtl/neuron_tile_feeder_if.sv
// Fabric-side bundle for neuron_tile_feeder: vmem load, spike-data stream and
// result writeback handshakes.
interface neuron_tile_feeder_if #(
   parameter int unsigned size_data = 8,
   parameter int unsigned size_vmem = 16,
   parameter int unsigned size_tile = 4
);
   localparam int unsigned data_w = size_data * size_tile;
   localparam int unsigned vmem_w = size_vmem * size_tile;

   logic [vmem_w-1:0] vmem_in;
   logic              vmem_valid;
   logic              vmem_ready;

   logic [data_w-1:0] data_in;
   logic              data_valid;
   logic              data_ready;
   logic              data_last;

   logic [vmem_w-1:0] wb_vmem;
   logic              wb_spike;
   logic              wb_valid;
   logic              wb_ready;

   // Fabric / scheduler side
   modport master (
      output vmem_in, vmem_valid, input vmem_ready,
      output data_in, data_valid, data_last, input data_ready,
      input  wb_vmem, wb_spike, wb_valid, output wb_ready
   );

   // Feeder side
   modport slave (
      input  vmem_in, vmem_valid, output vmem_ready,
      input  data_in, data_valid, data_last, output data_ready,
      output wb_vmem, wb_spike, wb_valid, input wb_ready
   );
endinterface

// File: rtl/neuron_tile_feeder.sv
// Sequences one neuron-tile batch: tile reset, vmem load, beat streaming with
// pauses, fixed drain window, then result writeback.
module neuron_tile_feeder #(
   parameter int unsigned size_control = 4,
   parameter int unsigned size_data    = 8,
   parameter int unsigned size_vmem    = 16,
   parameter int unsigned num_counters = 5,
   parameter int unsigned size_tile    = 4,
   parameter int unsigned drain_cycles = 2 * size_tile + 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   neuron_tile_feeder_if.slave             bus,
   output logic [size_control-1:0]         msgControl,
   output logic [size_data*size_tile-1:0]  msgData,
   output logic [size_vmem*size_tile-1:0]  msgVmem,
   input  logic [size_vmem*size_tile-1:0]  vmemOut,
   input  logic                            spikeBuffer,
   output logic                            busy,
   output logic                            trunc
);
   localparam int unsigned beat_limit = (2 ** num_counters) - 2;
   localparam int unsigned drain_w    = $clog2(drain_cycles + 1);

   // msgControl codes: bit0 run, bit1 memReady, bit2 memSD, bit3 finished
   localparam logic [size_control-1:0] ctl_off   = size_control'(4'b0000);
   localparam logic [size_control-1:0] ctl_load  = size_control'(4'b0011);
   localparam logic [size_control-1:0] ctl_pause = size_control'(4'b0001);
   localparam logic [size_control-1:0] ctl_beat  = size_control'(4'b0111);
   localparam logic [size_control-1:0] ctl_final = size_control'(4'b1111);
   localparam logic [size_control-1:0] ctl_drain = size_control'(4'b1001);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRST,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_WB
   } state_t;

   state_t                    state;
   logic [num_counters-1:0]   beat_cnt;
   logic [num_counters-1:0]   beat_cnt_inc;
   logic [drain_w-1:0]        drain_cnt;
   logic                      beat_accept;
   logic                      beat_final;

   assign busy           = (state != S_IDLE);
   assign bus.vmem_ready = (state == S_LOAD);
   assign bus.data_ready = (state == S_STREAM) && (beat_cnt < num_counters'(beat_limit));

   assign beat_accept  = bus.data_valid & bus.data_ready;
   assign beat_cnt_inc = beat_cnt + num_counters'(1);
   // A beat is final on data_last or when it fills the tile's beat counter
   assign beat_final   = bus.data_last | (beat_cnt_inc == num_counters'(beat_limit));

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         msgControl   <= '0;
         msgData      <= '0;
         msgVmem      <= '0;
         beat_cnt     <= '0;
         drain_cnt    <= '0;
         trunc        <= 1'b0;
         bus.wb_valid <= 1'b0;
         bus.wb_vmem  <= '0;
         bus.wb_spike <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               msgControl <= ctl_off;
               if (start) state <= S_TRST;
            end
            S_TRST: begin
               beat_cnt <= '0;
               trunc    <= 1'b0;
               state    <= S_LOAD;
            end
            S_LOAD: begin
               if (bus.vmem_valid) begin
                  msgVmem    <= bus.vmem_in;
                  msgControl <= ctl_load;
                  state      <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (beat_accept) begin
                  beat_cnt <= beat_cnt_inc;
                  msgData  <= bus.data_in;
                  if (beat_final) begin
                     msgControl <= ctl_final;
                     trunc      <= ~bus.data_last;
                     drain_cnt  <= '0;
                     state      <= S_DRAIN;
                  end else begin
                     msgControl <= ctl_beat;
                  end
               end else begin
                  msgControl <= ctl_pause;
               end
            end
            S_DRAIN: begin
               // First DRAIN cycle presents the finished beat; drain window follows
               msgControl <= ctl_drain;
               if (drain_cnt == drain_w'(drain_cycles)) begin
                  bus.wb_vmem  <= vmemOut;
                  bus.wb_spike <= spikeBuffer;
                  bus.wb_valid <= 1'b1;
                  state        <= S_WB;
               end else begin
                  drain_cnt <= drain_cnt + drain_w'(1);
               end
            end
            S_WB: begin
               if (bus.wb_ready) begin
                  bus.wb_valid <= 1'b0;
                  trunc        <= 1'b0;
                  msgControl   <= ctl_off;
                  state        <= S_IDLE;
               end
            end
            default: begin
               msgControl <= ctl_off;
               state      <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_tile_feeder.sv
// Directed bench for neuron_tile_feeder; the tile is a stub whose vmemOut tracks
// a free-running cycle count so capture timing is visible in wb_vmem.
module tb_neuron_tile_feeder;
   localparam int unsigned SD = 8;
   localparam int unsigned SV = 16;
   localparam int unsigned ST = 4;
   localparam int unsigned D  = 2 * ST + 3;
   localparam int unsigned DW = SD * ST;
   localparam int unsigned VW = SV * ST;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    msg_control;
   logic [DW-1:0] msg_data;
   logic [VW-1:0] msg_vmem;
   logic [VW-1:0] vmem_out;
   logic          spike_buffer;
   logic          busy;
   logic          trunc;
   int            cyc = 0;
   int            errors = 0;
   int            checks = 0;

   neuron_tile_feeder_if #(.size_data(SD), .size_vmem(SV), .size_tile(ST)) bus ();

   neuron_tile_feeder #(
      .size_control(4), .size_data(SD), .size_vmem(SV),
      .num_counters(5), .size_tile(ST), .drain_cycles(D)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .msgControl(msg_control), .msgData(msg_data), .msgVmem(msg_vmem),
      .vmemOut(vmem_out), .spikeBuffer(spike_buffer),
      .busy(busy), .trunc(trunc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [VW-1:0] tile_vmem(input int c);
      return {16'(c) + 16'd3, 16'(c) + 16'd2, 16'(c) + 16'd1, 16'(c)};
   endfunction

   assign vmem_out     = tile_vmem(cyc);
   assign spike_buffer = cyc[0];

   task automatic step;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      bus.vmem_in = '0; bus.vmem_valid = 1'b0;
      bus.data_in = '0; bus.data_valid = 1'b0; bus.data_last = 1'b0;
      bus.wb_ready = 1'b0;
   endtask

   // Drive start and the vmem load; returns at the first STREAM cycle
   task automatic begin_batch(input logic [VW-1:0] v);
      start = 1'b1; step; start = 1'b0;
      bus.vmem_in = v; bus.vmem_valid = 1'b1; step;
      step; bus.vmem_valid = 1'b0;
   endtask

   task automatic test_reset;
      clear_inputs; reset = 1'b1; step; step;
      checks++; if (msg_control !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", msg_control); end
      checks++; if (msg_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", msg_data); end
      checks++; if (msg_vmem !== '0) begin errors++; $display("FAIL reset_vmem: got %h want 0", msg_vmem); end
      checks++; if ({bus.wb_valid, bus.wb_spike, trunc, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got wbv/spk/trunc/busy=%b want 0000", {bus.wb_valid, bus.wb_spike, trunc, busy}); end
      checks++; if (bus.wb_vmem !== '0) begin errors++; $display("FAIL reset_wb_vmem: got %h want 0", bus.wb_vmem); end
      checks++; if ({bus.vmem_ready, bus.data_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.vmem_ready, bus.data_ready}); end
      reset = 1'b0; step; step;
      checks++; if ({busy, msg_control} !== 5'b0_0000) begin errors++; $display("FAIL idle_hold: got busy/ctl=%b want 00000", {busy, msg_control}); end
   endtask

   task automatic test_nominal;
      logic [VW-1:0] v;
      logic [DW-1:0] b;
      int cf;
      v = {4{16'h0010}}; b = {4{8'h01}}; cf = 0;
      bus.wb_ready = 1'b0;
      start = 1'b1; step; start = 1'b0;
      checks++; if ({busy, msg_control} !== 5'b1_0000) begin errors++; $display("FAIL nom_trst: got busy/ctl=%b want 10000", {busy, msg_control}); end
      bus.vmem_in = v; bus.vmem_valid = 1'b1; step;
      checks++; if ({bus.vmem_ready, msg_control} !== 5'b1_0000) begin errors++; $display("FAIL nom_load: got rdy/ctl=%b want 10000", {bus.vmem_ready, msg_control}); end
      step; bus.vmem_valid = 1'b0;
      checks++; if (msg_control !== 4'b0011) begin errors++; $display("FAIL nom_ctl_load: got %b want 0011", msg_control); end
      checks++; if (msg_vmem !== v) begin errors++; $display("FAIL nom_msg_vmem: got %h want %h", msg_vmem, v); end
      for (int i = 1; i <= 5; i++) begin
         bus.data_in = b; bus.data_valid = 1'b1; bus.data_last = (i == 5);
         if (i == 5) cf = cyc;
         step;
         checks++; if (msg_control !== ((i == 5) ? 4'b1111 : 4'b0111)) begin errors++; $display("FAIL nom_ctl_beat%0d: got %b want %b", i, msg_control, (i == 5) ? 4'b1111 : 4'b0111); end
         checks++; if (msg_data !== b) begin errors++; $display("FAIL nom_data_beat%0d: got %h want %h", i, msg_data, b); end
      end
      bus.data_valid = 1'b0; bus.data_last = 1'b0;
      for (int k = 0; k < int'(D); k++) begin
         step;
         checks++; if ({msg_control, bus.wb_valid} !== 5'b1001_0) begin errors++; $display("FAIL nom_drain%0d: got ctl/wbv=%b want 10010", k, {msg_control, bus.wb_valid}); end
      end
      step;
      checks++; if ({msg_control, bus.wb_valid, trunc} !== 6'b1001_1_0) begin errors++; $display("FAIL nom_wb: got ctl/wbv/trunc=%b want 100110", {msg_control, bus.wb_valid, trunc}); end
      checks++; if (bus.wb_vmem !== tile_vmem(cf + int'(D) + 1)) begin errors++; $display("FAIL nom_wb_vmem: got %h want %h", bus.wb_vmem, tile_vmem(cf + int'(D) + 1)); end
      checks++; if (bus.wb_spike !== 1'(cf + int'(D) + 1)) begin errors++; $display("FAIL nom_wb_spike: got %b want %b", bus.wb_spike, 1'(cf + int'(D) + 1)); end
      bus.wb_ready = 1'b1; step; bus.wb_ready = 1'b0;
      checks++; if ({msg_control, busy, bus.wb_valid} !== 6'b0000_0_0) begin errors++; $display("FAIL nom_idle: got ctl/busy/wbv=%b want 000000", {msg_control, busy, bus.wb_valid}); end
   endtask

   task automatic test_pause;
      int n;
      begin_batch({16'h0004, 16'h0003, 16'h0002, 16'h0001});
      for (int i = 1; i <= 5; i++) begin
         if (i == 3) begin
            bus.data_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
               step;
               checks++; if (msg_control !== 4'b0001) begin errors++; $display("FAIL pause_ctl%0d: got %b want 0001", p, msg_control); end
               checks++; if (msg_data !== {4{8'h22}}) begin errors++; $display("FAIL pause_hold%0d: got %h want %h", p, msg_data, {4{8'h22}}); end
            end
         end
         bus.data_in = {4{8'(17 * i)}}; bus.data_valid = 1'b1; bus.data_last = (i == 5);
         step;
         checks++; if ({msg_control, msg_data} !== {((i == 5) ? 4'b1111 : 4'b0111), {4{8'(17 * i)}}}) begin errors++; $display("FAIL pause_beat%0d: got ctl=%b data=%h want ctl=%b data=%h", i, msg_control, msg_data, (i == 5) ? 4'b1111 : 4'b0111, {4{8'(17 * i)}}); end
      end
      bus.data_valid = 1'b0; bus.data_last = 1'b0;
      n = 0;
      while (!bus.wb_valid && n < 40) begin step; n++; end
      checks++; if (n !== int'(D) + 1) begin errors++; $display("FAIL pause_wb_latency: got %0d want %0d", n, D + 1); end
      checks++; if ({bus.wb_valid, trunc} !== 2'b10) begin errors++; $display("FAIL pause_wb: got wbv/trunc=%b want 10", {bus.wb_valid, trunc}); end
      bus.wb_ready = 1'b1; step; bus.wb_ready = 1'b0;
   endtask

   task automatic test_trunc;
      int idx;
      int n;
      logic rdy;
      idx = 0;
      begin_batch({4{16'h0100}});
      bus.data_last = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.data_valid = 1'b1; bus.data_in = {4{8'(idx + 1)}}; rdy = bus.data_ready;
         step;
         if (rdy) begin
            idx++;
            checks++; if (msg_control !== ((idx == 30) ? 4'b1111 : 4'b0111)) begin errors++; $display("FAIL trunc_ctl_beat%0d: got %b want %b", idx, msg_control, (idx == 30) ? 4'b1111 : 4'b0111); end
         end
      end
      checks++; if (idx !== 30) begin errors++; $display("FAIL trunc_accepted: got %0d want 30", idx); end
      checks++; if (msg_data !== {4{8'd30}}) begin errors++; $display("FAIL trunc_last_data: got %h want %h", msg_data, {4{8'd30}}); end
      checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL trunc_ready_low: got %b want 0", bus.data_ready); end
      bus.data_valid = 1'b0;
      n = 0;
      while (!bus.wb_valid && n < 40) begin step; n++; end
      checks++; if ({bus.wb_valid, trunc} !== 2'b11) begin errors++; $display("FAIL trunc_flag: got wbv/trunc=%b want 11", {bus.wb_valid, trunc}); end
      bus.wb_ready = 1'b1; step; bus.wb_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int cf;
      int n;
      logic [VW-1:0] exp_v;
      begin_batch({4{16'h0aaa}});
      bus.data_in = {4{8'h5a}}; bus.data_valid = 1'b1; bus.data_last = 1'b1; cf = cyc;
      step;
      bus.data_valid = 1'b0; bus.data_last = 1'b0;
      exp_v = tile_vmem(cf + int'(D) + 1);
      n = 0;
      while (!bus.wb_valid && n < 40) begin step; n++; end
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL bp_wb_rise: got %b want 1 after %0d cycles", bus.wb_valid, n); end
      for (int k = 0; k < 4; k++) begin
         start = (k == 1);
         step;
         start = 1'b0;
         checks++; if ({bus.wb_valid, busy, msg_control, bus.wb_vmem} !== {1'b1, 1'b1, 4'b1001, exp_v}) begin errors++; $display("FAIL bp_hold%0d: got wbv=%b busy=%b ctl=%b vmem=%h want 1 1 1001 %h", k, bus.wb_valid, busy, msg_control, bus.wb_vmem, exp_v); end
      end
      bus.wb_ready = 1'b1; step; bus.wb_ready = 1'b0;
      checks++; if ({busy, bus.wb_valid, msg_control} !== 6'b0_0_0000) begin errors++; $display("FAIL bp_idle: got busy/wbv/ctl=%b want 000000", {busy, bus.wb_valid, msg_control}); end
      step; step;
      checks++; if ({busy, msg_control} !== 5'b0_0000) begin errors++; $display("FAIL bp_start_ignored: got busy/ctl=%b want 00000", {busy, msg_control}); end
   endtask

   task automatic test_reset_mid;
      logic seen;
      begin_batch({4{16'h0123}});
      for (int i = 1; i <= 3; i++) begin
         bus.data_in = {4{8'(i)}}; bus.data_valid = 1'b1; bus.data_last = 1'b0;
         step;
      end
      reset = 1'b1; step;
      checks++; if ({msg_control, msg_data, msg_vmem} !== '0) begin errors++; $display("FAIL rmid_msgs: got ctl=%b data=%h vmem=%h want 0", msg_control, msg_data, msg_vmem); end
      checks++; if ({busy, trunc, bus.wb_valid, bus.wb_spike, bus.data_ready, bus.vmem_ready} !== 6'b0) begin errors++; $display("FAIL rmid_flags: got %b want 000000", {busy, trunc, bus.wb_valid, bus.wb_spike, bus.data_ready, bus.vmem_ready}); end
      checks++; if (bus.wb_vmem !== '0) begin errors++; $display("FAIL rmid_wb_vmem: got %h want 0", bus.wb_vmem); end
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step;
         if (bus.wb_valid || busy) seen = 1'b1;
      end
      clear_inputs;
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_wb: got activity=%b want 0", seen); end
   endtask

   task automatic test_min_batch;
      int s;
      int nb;
      logic got;
      bus.wb_ready = 1'b1;
      bus.vmem_in = {4{16'h0777}}; bus.vmem_valid = 1'b1;
      bus.data_in = {4{8'h3c}}; bus.data_valid = 1'b1; bus.data_last = 1'b1;
      s = cyc; start = 1'b1; step; start = 1'b0;
      nb = 0; got = 1'b0;
      while (busy && nb < 40) begin
         if (bus.wb_valid) begin
            got = 1'b1;
            checks++; if ({bus.wb_vmem, trunc} !== {tile_vmem(s + 4 + int'(D)), 1'b0}) begin errors++; $display("FAIL min_wb: got vmem=%h trunc=%b want %h 0", bus.wb_vmem, trunc, tile_vmem(s + 4 + int'(D))); end
         end
         nb++;
         step;
      end
      clear_inputs;
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL min_wb_seen: got %b want 1", got); end
      checks++; if (nb !== 5 + int'(D)) begin errors++; $display("FAIL min_latency: got %0d busy cycles want %0d", nb, 5 + D); end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_pause;
      test_trunc;
      test_backpressure;
      test_reset_mid;
      test_min_batch;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
